// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 byte-stream adapter.
// Optional feature macro: SM4_KEY_REUSE_EN adds the LOAD_HDR start state.
package sm4_pkg;

    localparam int SM4_BLOCK_BYTES = 16;

    typedef logic [7:0] byte_t;
    typedef byte_t block_t [0:SM4_BLOCK_BYTES-1];

    typedef enum logic [2:0] {
        LOAD_KEY  = 3'd0,
        LOAD_DATA = 3'd1,
        COMPUTE   = 3'd2,
        SEND      = 3'd3
`ifdef SM4_KEY_REUSE_EN
        ,
        LOAD_HDR  = 3'd4
`endif
    } state_t;

`ifdef SM4_KEY_REUSE_EN
    localparam state_t START_STATE = LOAD_HDR;
`else
    localparam state_t START_STATE = LOAD_KEY;
`endif

endpackage

// File: rtl/sm4_stream_adapter_if.sv
// Byte-stream handshake bundle between a host and the SM4 adapter.
// Optional feature macro: SM4_KEY_REUSE_EN adds in_new_key.
interface sm4_stream_adapter_if;
    import sm4_pkg::*;

    logic  in_valid;
    logic  in_ready;
    byte_t in_data;
    logic  in_mode;
`ifdef SM4_KEY_REUSE_EN
    logic  in_new_key;
`endif
    logic  out_valid;
    logic  out_ready;
    byte_t out_data;
    logic  out_last;

`ifdef SM4_KEY_REUSE_EN
    modport master (
        output in_valid, in_data, in_mode, in_new_key, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_mode, in_new_key, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
`else
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
`endif

endinterface

// File: rtl/sm4_byte_shifter.sv
// 16-entry byte register: indexed byte write, whole-block parallel load,
// indexed byte read and full-block view.
module sm4_byte_shifter
    import sm4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  byte_t      wr_data,
    input  logic       ld_en,
    input  block_t     ld_data,
    input  logic [3:0] rd_idx,
    output byte_t      rd_data,
    output block_t     q
);

    block_t mem_q;
    block_t mem_d;

    // Next contents: a parallel load takes priority over a single-byte write.
    always_comb begin
        mem_d = mem_q;
        if (ld_en) begin
            mem_d = ld_data;
        end else if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SM4_BLOCK_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign q       = mem_q;

endmodule

// File: rtl/sm4_stream_adapter.sv
// Byte-serial front/back end for the combinational SM4 core: gathers key and
// data bytes, holds them on the core for CALC_CYCLES+1 cycles, captures dst and
// streams the 16 result bytes out.
// Optional feature macro: SM4_KEY_REUSE_EN (first byte may skip key loading).
//
// state     | meaning
// LOAD_HDR  | (key reuse only) first byte decides: new key or data-only
// LOAD_KEY  | accepting key bytes into mk[cnt]
// LOAD_DATA | accepting data bytes into src[cnt]
// COMPUTE   | core inputs held, settle counter running down
// SEND      | streaming result[cnt] out
module sm4_stream_adapter
    import sm4_pkg::*;
#(
    parameter int CALC_CYCLES = 1,
    parameter int BLOCK_BYTES = SM4_BLOCK_BYTES
) (
    input  logic                        clk,
    input  logic                        rst,
    sm4_stream_adapter_if.slave         strm,
    output block_t                      sm4_mk,
    output block_t                      sm4_src,
    output logic                        sm4_mode,
    input  block_t                      sm4_dst
);

    localparam logic [3:0] LAST_IDX    = 4'(BLOCK_BYTES - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(CALC_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] settle_q, settle_d;
    logic       mode_q, mode_d;

    logic       in_ready;
    logic       out_valid;
    byte_t      out_data;
    logic       out_last;
    logic       mk_we;
    logic       src_we;
    logic       res_ld;
    logic       in_acc;
    logic       out_cons;
    byte_t      res_rd;
    byte_t      unused_mk_rd;
    byte_t      unused_src_rd;
    block_t     unused_res_q;
    block_t     blk_zero;

    assign blk_zero = '{default: 8'h00};
    assign in_acc   = strm.in_valid && in_ready;
    assign out_cons = out_valid && strm.out_ready;

    // State, counters and latched mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= START_STATE;
            cnt_q    <= '0;
            settle_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        case (state_q)
`ifdef SM4_KEY_REUSE_EN
            LOAD_HDR: begin
                if (in_acc) begin
                    mode_d  = strm.in_mode;
                    cnt_d   = 4'd1;
                    state_d = strm.in_new_key ? LOAD_KEY : LOAD_DATA;
                end
            end
`endif
            LOAD_KEY: begin
                if (in_acc) begin
                    if (cnt_q == 4'd0) begin
                        mode_d = strm.in_mode;
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (in_acc) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d    = 4'd0;
                        settle_d = SETTLE_INIT;
                        state_d  = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (settle_q == 4'd0) begin
                    state_d = SEND;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SEND: begin
                if (out_cons) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = 4'd0;
                        state_d = START_STATE;
                    end
                end
            end
            default: state_d = START_STATE;
        endcase
    end

    // Handshake outputs and register write strobes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        mk_we     = 1'b0;
        src_we    = 1'b0;
        res_ld    = 1'b0;
        case (state_q)
`ifdef SM4_KEY_REUSE_EN
            LOAD_HDR: begin
                in_ready = 1'b1;
                mk_we    = strm.in_valid && strm.in_new_key;
                src_we   = strm.in_valid && !strm.in_new_key;
            end
`endif
            LOAD_KEY: begin
                in_ready = 1'b1;
                mk_we    = strm.in_valid;
            end
            LOAD_DATA: begin
                in_ready = 1'b1;
                src_we   = strm.in_valid;
            end
            COMPUTE: begin
                res_ld = (settle_q == 4'd0);
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = res_rd;
                out_last  = (cnt_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid;
    assign strm.out_data  = out_data;
    assign strm.out_last  = out_last;
    assign sm4_mode       = mode_q;

    sm4_byte_shifter u_mk (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mk_we),
        .wr_idx  (cnt_q),
        .wr_data (strm.in_data),
        .ld_en   (1'b0),
        .ld_data (blk_zero),
        .rd_idx  (cnt_q),
        .rd_data (unused_mk_rd),
        .q       (sm4_mk)
    );

    sm4_byte_shifter u_src (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (src_we),
        .wr_idx  (cnt_q),
        .wr_data (strm.in_data),
        .ld_en   (1'b0),
        .ld_data (blk_zero),
        .rd_idx  (cnt_q),
        .rd_data (unused_src_rd),
        .q       (sm4_src)
    );

    sm4_byte_shifter u_res (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_idx  (4'd0),
        .wr_data (8'h00),
        .ld_en   (res_ld),
        .ld_data (sm4_dst),
        .rd_idx  (cnt_q),
        .rd_data (res_rd),
        .q       (unused_res_q)
    );

endmodule

// File: tb/tb_sm4_stream_adapter.sv
// Bench for sm4_stream_adapter: one adapter with CALC_CYCLES = 1 and one with
// CALC_CYCLES = 4, each wired to a stand-in core. The stand-in knows the
// standard SM4 vector in both directions and otherwise returns a keyed mix.
`timescale 1ns/1ps
module tb_sm4_stream_adapter;
    import sm4_pkg::*;

    localparam logic [127:0] KEY_V = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT_V  = 128'h681edf34d206965e86b3e94f536e4246;
`ifdef SM4_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic  drv_valid   = 1'b0;
    byte_t drv_data    = 8'h00;
    logic  drv_mode    = 1'b0;
    logic  drv_new_key = 1'b1;
    logic  drv_ready   = 1'b0;
    logic  sel4        = 1'b0;
    int unsigned acc_cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    sm4_stream_adapter_if if1 ();
    sm4_stream_adapter_if if4 ();

    assign if1.in_valid  = drv_valid & ~sel4;
    assign if1.in_data   = drv_data;
    assign if1.in_mode   = drv_mode;
    assign if1.out_ready = drv_ready;
    assign if4.in_valid  = drv_valid & sel4;
    assign if4.in_data   = drv_data;
    assign if4.in_mode   = drv_mode;
    assign if4.out_ready = drv_ready;
`ifdef SM4_KEY_REUSE_EN
    assign if1.in_new_key = drv_new_key;
    assign if4.in_new_key = drv_new_key;
`endif

    logic  cur_in_ready, cur_out_valid, cur_out_last;
    byte_t cur_out_data;
    assign cur_in_ready  = sel4 ? if4.in_ready  : if1.in_ready;
    assign cur_out_valid = sel4 ? if4.out_valid : if1.out_valid;
    assign cur_out_last  = sel4 ? if4.out_last  : if1.out_last;
    assign cur_out_data  = sel4 ? if4.out_data  : if1.out_data;

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                             input logic enc);
        if (enc && k == KEY_V && d == KEY_V) return CT_V;
        if (!enc && k == KEY_V && d == CT_V) return KEY_V;
        return d ^ {k[119:0], k[127:120]} ^ {16{7'h00, enc}};
    endfunction

    block_t mk1, src1, dst1, mk4, src4, dst4;
    logic   mode1, mode4;
    logic [127:0] mk1_p, src1_p, dst1_p, mk4_p, src4_p, dst4_p;

    always_comb begin
        mk1_p  = '0;
        src1_p = '0;
        mk4_p  = '0;
        src4_p = '0;
        for (int i = 0; i < 16; i++) begin
            mk1_p[127-8*i -: 8]  = mk1[i];
            src1_p[127-8*i -: 8] = src1[i];
            mk4_p[127-8*i -: 8]  = mk4[i];
            src4_p[127-8*i -: 8] = src4[i];
        end
    end

    assign dst1_p = core_fn(mk1_p, src1_p, mode1);
    assign dst4_p = core_fn(mk4_p, src4_p, mode4);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            dst1[i] = dst1_p[127-8*i -: 8];
            dst4[i] = dst4_p[127-8*i -: 8];
        end
    end

    sm4_stream_adapter #(.CALC_CYCLES(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .strm     (if1),
        .sm4_mk   (mk1),
        .sm4_src  (src1),
        .sm4_mode (mode1),
        .sm4_dst  (dst1)
    );

    sm4_stream_adapter #(.CALC_CYCLES(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .strm     (if4),
        .sm4_mk   (mk4),
        .sm4_src  (src4),
        .sm4_mode (mode4),
        .sm4_dst  (dst4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: collects accepted bytes, queues the expected
    // result block and checks the selected adapter on every falling edge.
    byte_t        exp_q[$];
    logic [127:0] m_key  = '0;
    logic [127:0] m_dat  = '0;
    logic [127:0] m_res  = '0;
    int           m_idx  = 0;
    logic         m_mode = 1'b0;
    bit           m_busy = 1'b0;
    bit           prev_stall = 1'b0;
    byte_t        prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_out_valid", cur_out_valid, 0);
            check("reset_in_ready", cur_in_ready, 1);
            exp_q.delete();
            m_key      = '0;
            m_idx      = 0;
            m_busy     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", cur_in_ready, !m_busy);
            if (cur_out_valid && exp_q.size() == 0) begin
                check("spurious_out_valid", cur_out_valid, 0);
            end
            if (cur_out_valid && exp_q.size() != 0) begin
                check("out_data", cur_out_data, exp_q[0]);
                check("out_last", cur_out_last, exp_q.size() == 1);
                if (prev_stall) check("out_hold", cur_out_data, prev_data);
            end
            prev_stall = cur_out_valid && !drv_ready;
            prev_data  = cur_out_data;
            if (cur_out_valid && drv_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_busy = 1'b0;
            end
            if (drv_valid && cur_in_ready && !m_busy) begin
                if (m_idx == 0) begin
                    m_mode = drv_mode;
                    if (REUSE && !drv_new_key) m_idx = 16;
                end
                if (m_idx < 16) m_key[127-8*m_idx -: 8] = drv_data;
                else            m_dat[127-8*(m_idx-16) -: 8] = drv_data;
                m_idx++;
                if (m_idx == 32) begin
                    m_res = core_fn(m_key, m_dat, m_mode);
                    for (int i = 0; i < 16; i++) exp_q.push_back(m_res[127-8*i -: 8]);
                    m_idx  = 0;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // Offers the first n bytes of blk (MSB first) with in_valid held high.
    task automatic send_bytes(input logic [127:0] blk, input int n, input logic mode,
                              input logic nk);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            drv_valid   = 1'b1;
            drv_data    = blk[127-8*i -: 8];
            drv_mode    = mode;
            drv_new_key = nk;
            @(negedge clk);
            while (!cur_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("in_ready_timeout", cur_in_ready, 1);
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        drv_valid = 1'b0;
    endtask

    // Collects one 16-byte result; optional random backpressure and in_valid noise.
    task automatic recv_block(input bit stall, input bit noise, output logic [127:0] got,
                              output int nlast, output int lat);
        int nb = 0;
        int t  = 0;
        got   = '0;
        nlast = 0;
        lat   = -1;
        while (nb < 16 && t < 400) begin
            drv_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                drv_valid = 1'($urandom_range(0, 1));
                drv_data  = 8'($urandom);
            end
            @(negedge clk);
            if (cur_out_valid && lat < 0) lat = int'(cyc - acc_cyc);
            if (cur_out_valid && drv_ready) begin
                got[127-8*nb -: 8] = cur_out_data;
                if (cur_out_last) nlast++;
                nb++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        check("recv_byte_count", nb, 16);
    endtask

    initial begin
        logic [127:0] got;
        int nl;
        int lat;

        repeat (3) @(negedge clk);
        check("reset_out_data", if1.out_data, 0);
        check("reset_out_last", if1.out_last, 0);
        check("reset_sm4_mode", mode1, 0);
        check("reset_sm4_mk", mk1_p, 0);
        check("reset_sm4_src", src1_p, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        recv_block(1'b0, 1'b0, got, nl, lat);
        check("enc_block", got, CT_V);
        check("enc_last_count", nl, 1);
        check("enc_latency", lat, 2);
        check("enc_core_mode", mode1, 1);
        check("enc_core_key", mk1_p, KEY_V);

        send_bytes(KEY_V, 16, 1'b0, 1'b1);
        send_bytes(CT_V, 16, 1'b0, 1'b1);
        recv_block(1'b1, 1'b1, got, nl, lat);
        check("dec_block", got, KEY_V);
        check("dec_last_count", nl, 1);
        check("dec_latency", lat, 2);
        check("dec_core_mode", mode1, 0);

        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        send_bytes(KEY_V, 4, 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_out_valid", cur_out_valid, 0);
            check("post_reset_in_ready", cur_in_ready, 1);
        end
        check("post_reset_key", mk1_p, 0);
        @(posedge clk);
        #1;
        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        recv_block(1'b1, 1'b0, got, nl, lat);
        check("post_reset_block", got, CT_V);

`ifdef SM4_KEY_REUSE_EN
        send_bytes(KEY_V, 16, 1'b1, 1'b0);
        @(negedge clk);
        check("reuse_ready_after_16", cur_in_ready, 0);
        @(posedge clk);
        #1;
        recv_block(1'b0, 1'b0, got, nl, lat);
        check("reuse_block", got, CT_V);
        check("reuse_latency", lat, 2);
`endif

        sel4 = 1'b1;
        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        send_bytes(KEY_V, 16, 1'b1, 1'b1);
        recv_block(1'b0, 1'b0, got, nl, lat);
        check("calc4_block", got, CT_V);
        check("calc4_latency", lat, 5);
        check("calc4_last_count", nl, 1);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
